// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch PC owner and prefetch FIFO of {pc, ins} with redirect flush
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] fetch_pc;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic full, push, pop;
  // full blocks push even when popping, so out_ready never reaches imem_addr
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    push = fetch_en & ~redirect_valid & ~full;
    pop = out_valid & out_ready & ~redirect_valid;
    imem_addr = fetch_pc;
    out_valid = count != 0;
    out_pc = pc_mem[rd_ptr];
    out_ins = ins_mem[rd_ptr];
    busy = out_valid | (fetch_en & ~full);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        ins_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr] <= fetch_pc;
        ins_mem[wr_ptr] <= imem_ins;
        wr_ptr <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop) count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: table-driven cycle vectors plus hand-written back-pressure, drain and reset sequences
module tb_ifetch_ctrl;
  logic clk = 1'b0;
  logic rst, fetch_en, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_ins, out_pc, out_ins;
  logic out_valid, busy;
  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic chk;
    logic rst;
    logic en;
    logic rv;
    logic [31:0] rpc;
    logic rdy;
    logic ov;
    logic [31:0] opc;
    logic [31:0] addr;
    logic busy;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'd4 ? 32'h0050_0193 : a == 32'd8 ? 32'h0031_8233 : ~a;
  endfunction

  assign imem_ins = rom(imem_addr);

  ifetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_ins(imem_ins),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins), .busy(busy)
  );

  function automatic vec_t mk(input logic c, r, e, v, input logic [31:0] p, input logic y,
                              input logic ov, input logic [31:0] opc, addr, input logic b);
    return '{chk: c, rst: r, en: e, rv: v, rpc: p, rdy: y, ov: ov, opc: opc, addr: addr, busy: b};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, e, v, input logic [31:0] p, input logic y);
    @(negedge clk);
    rst = r;
    fetch_en = e;
    redirect_valid = v;
    redirect_pc = p;
    out_ready = y;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [31:0] opc, addr, input logic b);
    cmp({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    cmp({tag, " imem_addr"}, imem_addr, addr);
    cmp({tag, " busy"}, {31'd0, busy}, {31'd0, b});
    if (ov) begin
      cmp({tag, " out_pc"}, out_pc, opc);
      cmp({tag, " out_ins"}, out_ins, rom(opc));
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    //                c  rst en rv rpc            rdy ov opc            addr           busy
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         0,  0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,         0,  0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  0, 32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'h0,         32'h4,         1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'h4,         32'h8,         1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'h8,         32'hC,         1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         0,  1, 32'hC,         32'h10,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         0,  1, 32'hC,         32'h14,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         0,  1, 32'hC,         32'h14,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'hC,         32'h14,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'h10,        32'h14,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         0,  1, 32'h14,        32'h18,        1));
    vecs.push_back(mk(1, 0, 1, 1, 32'h22,        0,  1, 32'h14,        32'h1C,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  0, 32'h0,         32'h20,        1));
    vecs.push_back(mk(1, 0, 1, 1, 32'hFFFF_FFFC, 1,  1, 32'h20,        32'h24,        1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  0, 32'h0,         32'hFFFF_FFFC, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 32'h0,         1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         1,  1, 32'h0,         32'h4,         1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         0,  1, 32'h4,         32'h8,         1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1,  1, 32'h4,         32'h8,         1));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1,  0, 32'h0,         32'h8,         0));
    vecs.push_back(mk(1, 0, 0, 1, 32'h103,       1,  0, 32'h0,         32'h8,         0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1,  0, 32'h0,         32'h100,       0));
    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].en, vecs[k].rv, vecs[k].rpc, vecs[k].rdy);
      if (vecs[k].chk) expect_out($sformatf("vec%0d", k), vecs[k].ov, vecs[k].opc, vecs[k].addr, vecs[k].busy);
    end

    // back-pressure from reset: head stays at RESET_PC while fetch_pc freezes at 8
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_out("bp_reset", 0, 0, 32'h0, 0);
    cmp("bp_reset out_pc", out_pc, 32'h0);
    cmp("bp_reset out_ins", out_ins, 32'h0);
    step(0, 1, 0, 0, 0);
    expect_out("bp_first", 0, 0, 32'h0, 1);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0, 0);
      expect_out($sformatf("bp_hold%0d", k), 1, 32'h0, k == 0 ? 32'h4 : 32'h8, 1);
    end
    step(0, 1, 0, 0, 1);
    expect_out("bp_rel0", 1, 32'h0, 32'h8, 1);
    step(0, 1, 0, 0, 1);
    expect_out("bp_rel1", 1, 32'h4, 32'h8, 1);
    step(0, 1, 0, 0, 0);
    expect_out("bp_rel2", 1, 32'h8, 32'hC, 1);

    // drop fetch_en with a full FIFO: both entries drain, then fetch_pc holds
    step(0, 0, 0, 0, 0);
    expect_out("drain_full", 1, 32'h8, 32'h10, 1);
    step(0, 0, 0, 0, 1);
    expect_out("drain0", 1, 32'h8, 32'h10, 1);
    step(0, 0, 0, 0, 1);
    expect_out("drain1", 1, 32'hC, 32'h10, 1);
    step(0, 0, 0, 0, 1);
    expect_out("drain_empty", 0, 0, 32'h10, 0);
    step(0, 0, 0, 0, 1);
    expect_out("drain_hold", 0, 0, 32'h10, 0);

    // one-cycle reset mid-stream discards the buffered entry
    step(0, 1, 0, 0, 0);
    expect_out("mid_fetch", 0, 0, 32'h10, 1);
    step(1, 1, 0, 0, 0);
    expect_out("mid_busy", 1, 32'h10, 32'h14, 1);
    step(0, 1, 0, 0, 1);
    expect_out("mid_after", 0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 1);
    expect_out("mid_first", 1, 32'h0, 32'h4, 1);
    step(0, 1, 0, 0, 1);
    expect_out("mid_second", 1, 32'h4, 32'h8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the RV32E core. Owns the fetch PC, drives the address of the combinational instruction ROM (imem), and buffers fetched {pc, instruction} pairs in a small prefetch FIFO for decode with a valid/ready handshake. Branch and jump redirects from execute flush the FIFO and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, prefetch FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  1 = fetch allowed; 0 = no new pushes, FIFO still drains.
- imem_addr  out  32  address to imem; equals fetch_pc.
- imem_ins  in  32  imem read data, valid in the same cycle as imem_addr.
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  32  PC of the head entry.
- out_ins  out  32  instruction of the head entry.
- busy  out  1  1 when count != 0 or a push is pending; used by halt and debug logic.

## Operation
- State:
  - fetch_pc (32 bits).
  - FIFO with DEPTH entries, each {pc, ins}.
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping.
  - count, log2(DEPTH)+1 bits.
- imem_addr = fetch_pc, combinationally.
- Per-cycle signals:
  - push = fetch_en & ~redirect_valid & (count < DEPTH).
  - pop = out_valid & out_ready & ~redirect_valid.
- On push:
  - Write {fetch_pc, imem_ins} at wr_ptr.
  - wr_ptr increments.
  - fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- On pop: rd_ptr increments.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Full FIFO: push is blocked even if a pop happens in the same cycle. This keeps any combinational path from out_ready to imem_addr out of the design. With DEPTH=2 the FIFO still sustains 1 instruction per cycle (steady-state count = 1).
- Redirect has priority over push and pop. When redirect_valid=1, at the edge:
  - count <= 0, rd_ptr <= 0, wr_ptr <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No entry is written or consumed. A handshake presented in that cycle is void, and decode must treat the head as discarded.
- out_valid = (count != 0); out_pc and out_ins come from the entry at rd_ptr.
- fetch_en=0: fetch_pc holds and the FIFO drains normally. A redirect while fetch_en=0 still flushes the FIFO and loads fetch_pc.
- Reset has priority over everything. Reset values:
  - fetch_pc = RESET_PC.
  - count, rd_ptr, wr_ptr = 0.
  - out_valid = 0, busy = 0.
  - out_pc and out_ins are don't-care while out_valid = 0, but must be 0 after reset.
- A reset asserted mid-stream discards all entries. The first post-reset push is RESET_PC.

## Timing
- Fetch latency: an instruction pushed at edge N is visible on out_* after edge N. Decode can take it in the cycle after its fetch.
- Reset: after rst deasserts, with fetch_en=1:
  - First push happens at the first edge with rst=0.
  - out_valid=1 in the following cycle with out_pc=RESET_PC.
- Redirect penalty: with redirect_valid sampled at edge R:
  - out_valid=0 in cycle R+1.
  - Target is pushed at edge R+1.
  - out_valid=1 with out_pc=target in cycle R+2.
- Back-pressure: with out_ready=0, the FIFO fills to DEPTH in DEPTH cycles, then fetch_pc freezes. out_* are stable while out_valid=1 and out_ready=0.
- No output depends combinationally on out_ready or redirect_valid. imem_addr depends only on registered state.

## Test plan
- Reset then stream, using the team test ROM (addr 4 = 32'h00500193, addr 8 = 32'h00318233), with out_ready=1 and fetch_en=1:
  - Required: out_pc sequence 0, 4, 8, 12, … one per cycle; out_ins at pc 4 = 32'h00500193; count never exceeds 1.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles after the first valid.
  - Required: count saturates at 2; fetch_pc stays at 8; out_pc stays 0 throughout.
  - Release out_ready: required delivery 0, 4, 8 in order with no loss or duplication.
- Redirect:
  - Pulse redirect_valid with redirect_pc=32'h0000_0022 while the FIFO holds 2 entries.
  - Required: out_valid=0 the next cycle; the cycle after, out_pc=32'h0000_0020; the old entries are never delivered.
- Redirect with a simultaneous handshake:
  - Assert out_ready=1 in the same cycle as redirect_valid.
  - Required: the pop is ignored, rd_ptr resets, and the next delivered pc is the target.
- PC wrap:
  - Redirect to 32'hFFFF_FFFC.
  - Required: delivered pcs are FFFF_FFFC, then 0000_0000, then 0000_0004.
- fetch_en and reset mid-operation:
  - Drop fetch_en with the FIFO full. Required: the FIFO drains 2 entries, then out_valid=0 while fetch_pc holds.
  - Assert rst for 1 cycle while busy. Required: count=0 and out_valid=0 the cycle after; the first subsequent out_pc=RESET_PC.
